run_ctrl: RTL and testbench
===========================

// Module: run_ctrl
// PURPOSE
//  Program-launch sequencer that sits directly upstream of fetch. It accepts a run
//  request from the host via a req/ack handshake and drives fetch's start_i and
//  start_address_i. It watches pc and the decoded opcode from instr_rom for the
//  HALT opcode, then reports completion, the halt PC and the elapsed run cycle count.
// PARAMETERS
//  ADDR_WIDTH    16     width of start address / PC
//  CNT_WIDTH     16     width of run-cycle counter
//  START_CYCLES  2      cycles start_o is held high (1..15)
//  HALT_OPCODE   4'hF   opcode value that ends a run
//  WDOG_LIMIT    1000   RUN-cycle limit before forced stop (WATCHDOG_EN only)
// PORTS
//  clk              in   1          system clock, rising edge
//  rst_n            in   1          asynchronous active-low reset
//  req_i            in   1          host run request (level)
//  addr_i           in   ADDR_WIDTH program start address, sampled with req_i
//  abort_i          in   1          host abort; returns to IDLE from any state
//  pc_i             in   ADDR_WIDTH current PC from fetch
//  opcode_i         in   4          decoded opcode from instr_rom
//  ack_o            out  1          1-cycle pulse: request accepted
//  busy_o           out  1          high in LOAD and RUN
//  start_o          out  1          to fetch start_i
//  start_address_o  out  ADDR_WIDTH to fetch start_address_i (registered)
//  done_o           out  1          1-cycle pulse: run finished (halt or timeout)
//  halt_pc_o        out  ADDR_WIDTH pc_i captured at finish
//  cycles_o         out  CNT_WIDTH  RUN cycles of the last or current run
//  timeout_o        out  1          sticky: last run ended by watchdog
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; all outputs 0; counters 0.
//  - FSM: IDLE -> LOAD -> RUN -> DONE -> IDLE. All outputs are registered.
//  - IDLE: when req_i=1 at a clock edge: latch addr_i into start_address_o, clear
//    cycles_o/halt_pc_o/timeout_o, pulse ack_o the next cycle, and enter LOAD.
//  - req_i outside IDLE: ignored, no ack_o. A req_i still high in IDLE after
//    DONE starts a new run (back-to-back runs are legal).
//  - LOAD: start_o=1 for exactly START_CYCLES cycles, then RUN. opcode_i is not
//    checked in LOAD.
//  - RUN: start_o=0. cycles_o increments by 1 each cycle and saturates at all-ones.
//    If opcode_i==HALT_OPCODE: capture pc_i into halt_pc_o and enter DONE.
//    The halting cycle is counted.
//  - DONE: done_o=1 for 1 cycle, busy_o=0, then IDLE. Status outputs hold until
//    the next accepted request.
//  - abort_i=1 in LOAD/RUN/DONE: next state IDLE. start_o=0, no done_o, and status
//    is frozen at its current value. If abort_i and HALT occur in the same cycle,
//    abort wins. abort_i in IDLE has no effect. If abort_i and req_i are both high
//    in IDLE, the request is NOT accepted.
//  - Reset mid-run: immediate return to IDLE with all outputs 0.
//  - busy_o = (state==LOAD || state==RUN).
// CONFIGURATION
//  WATCHDOG_EN defined:
//   - In RUN, when cycles_o reaches WDOG_LIMIT without a HALT: set timeout_o=1,
//     capture pc_i into halt_pc_o, and enter DONE (done_o pulses).
//   - If HALT and the limit occur in the same cycle, HALT wins and timeout_o=0.
//  WATCHDOG_EN undefined:
//   - No limit check; a run ends only on HALT or abort_i.
//   - timeout_o is tied to 0. WDOG_LIMIT is unused.
// TESTING
//  1 rst_n=0 mid-LOAD -> all outputs 0 immediately (async); after release, state=IDLE.
//  2 req_i=1, addr_i=16'h0005; HALT at pc_i=16'h0009 on 5th RUN cycle -> ack_o pulse,
//    start_o=1 for 2 cycles, start_address_o=0005, done_o pulse, halt_pc_o=0009,
//    cycles_o=5.
//  3 req_i held high across DONE with addr_i=16'h0000 -> second ack_o the cycle after
//    IDLE is re-entered; cycles_o cleared to 0 and restarts.
//  4 abort_i=1 on 3rd RUN cycle, same cycle as HALT -> IDLE, no done_o, cycles_o=3,
//    halt_pc_o unchanged.
//  5 req_i pulsed during RUN -> no ack_o; run completes normally.
//  6 WATCHDOG_EN, WDOG_LIMIT=8, no HALT -> done_o after 8 RUN cycles, timeout_o=1,
//    cycles_o=8. Without the macro: no done_o and timeout_o=0.

Source files
------------

// File: rtl/run_ctrl_if.sv
// run_ctrl_if: host/fetch-facing bundle of the program-launch sequencer.
//   master: drives req/addr/abort/pc/opcode, observes the status outputs.
//   slave : run_ctrl side; drives ack/busy/start/startAddress/done/haltPc/cycles/timeout.
interface run_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] pc;
  logic [3:0]            opcode;
  logic                  ack;
  logic                  busy;
  logic                  start;
  logic [ADDR_WIDTH-1:0] startAddress;
  logic                  done;
  logic [ADDR_WIDTH-1:0] haltPc;
  logic [CNT_WIDTH-1:0]  cycles;
  logic                  timeout;

  modport master (
    output req, addr, abort, pc, opcode,
    input  ack, busy, start, startAddress, done, haltPc, cycles, timeout
  );

  modport slave (
    input  req, addr, abort, pc, opcode,
    output ack, busy, start, startAddress, done, haltPc, cycles, timeout
  );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: program-launch sequencer upstream of fetch.
// Accepts a host run request, pulses fetch start for START_CYCLES cycles, then
// counts RUN cycles until the HALT opcode (or abort) and reports halt PC / count.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    run_ctrl_if.slave (req/addr/abort/pc/opcode in; ack/busy/start/
//          startAddress/done/haltPc/cycles/timeout out, all registered)
// Build option: define WATCHDOG_EN to end a RUN after WDOG_LIMIT cycles with
// timeout set; otherwise timeout stays 0 and WDOG_LIMIT is unused.
module run_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned START_CYCLES = 2,
  parameter logic [3:0]  HALT_OPCODE  = 4'hF,
  parameter int unsigned WDOG_LIMIT   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  run_ctrl_if.slave   bus
);

  localparam int unsigned LOAD_CNT_WIDTH = 4;
  localparam logic [LOAD_CNT_WIDTH-1:0] LoadLast = LOAD_CNT_WIDTH'(START_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]      CntMax   = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {Idle, Load, Run, Done} state_t;

  state_t                    state, nextState;
  logic [LOAD_CNT_WIDTH-1:0] loadCnt, loadCntNxt;

  logic                  ack, ackNxt;
  logic                  busy, busyNxt;
  logic                  start, startNxt;
  logic [ADDR_WIDTH-1:0] startAddress, startAddressNxt;
  logic                  done, doneNxt;
  logic [ADDR_WIDTH-1:0] haltPc, haltPcNxt;
  logic [CNT_WIDTH-1:0]  cycles, cyclesNxt;
  logic                  timeout, timeoutNxt;

  logic isHalt;
  logic wdogHit;
  logic accept;

  assign isHalt = (bus.opcode == HALT_OPCODE);
  // abort in IDLE blocks acceptance of a simultaneous request
  assign accept = bus.req && !bus.abort;

`ifdef WATCHDOG_EN
  localparam logic [CNT_WIDTH-1:0] WdogCnt = CNT_WIDTH'(WDOG_LIMIT);
  // cycles already counts the current RUN cycle, so the limit trips in cycle WDOG_LIMIT
  assign wdogHit = (cycles >= WdogCnt);
`else
  localparam bit WdogIgnored = (WDOG_LIMIT != 0);
  assign wdogHit = WdogIgnored & 1'b0;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= Idle;
      loadCnt      <= '0;
      ack          <= 1'b0;
      busy         <= 1'b0;
      start        <= 1'b0;
      startAddress <= '0;
      done         <= 1'b0;
      haltPc       <= '0;
      cycles       <= '0;
      timeout      <= 1'b0;
    end else begin
      state        <= nextState;
      loadCnt      <= loadCntNxt;
      ack          <= ackNxt;
      busy         <= busyNxt;
      start        <= startNxt;
      startAddress <= startAddressNxt;
      done         <= doneNxt;
      haltPc       <= haltPcNxt;
      cycles       <= cyclesNxt;
      timeout      <= timeoutNxt;
    end
  end

  // Next-state logic; abort wins over HALT and the watchdog
  always_comb begin
    nextState  = state;
    loadCntNxt = loadCnt;
    case (state)
      Idle: begin
        if (accept) begin
          nextState  = Load;
          loadCntNxt = '0;
        end
      end
      Load: begin
        if (bus.abort) begin
          nextState = Idle;
        end else if (loadCnt == LoadLast) begin
          nextState = Run;
        end else begin
          loadCntNxt = loadCnt + LOAD_CNT_WIDTH'(1);
        end
      end
      Run: begin
        if (bus.abort) begin
          nextState = Idle;
        end else if (isHalt || wdogHit) begin
          nextState = Done;
        end
      end
      Done:    nextState = Idle;
      default: nextState = Idle;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    ackNxt          = 1'b0;
    busyNxt         = (nextState == Load) || (nextState == Run);
    startNxt        = (nextState == Load);
    doneNxt         = 1'b0;
    startAddressNxt = startAddress;
    haltPcNxt       = haltPc;
    cyclesNxt       = cycles;
    timeoutNxt      = timeout;
    case (state)
      Idle: begin
        if (accept) begin
          ackNxt          = 1'b1;
          startAddressNxt = bus.addr;
          haltPcNxt       = '0;
          cyclesNxt       = '0;
          timeoutNxt      = 1'b0;
        end
      end
      Load: begin
        // entering RUN counts the first RUN cycle
        if (!bus.abort && nextState == Run) begin
          cyclesNxt = cycles + CNT_WIDTH'(1);
        end
      end
      Run: begin
        if (!bus.abort) begin
          if (isHalt) begin
            haltPcNxt = bus.pc;
            doneNxt   = 1'b1;
          end else if (wdogHit) begin
            haltPcNxt  = bus.pc;
            timeoutNxt = 1'b1;
            doneNxt    = 1'b1;
          end else if (cycles != CntMax) begin
            cyclesNxt = cycles + CNT_WIDTH'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.ack          = ack;
  assign bus.busy         = busy;
  assign bus.start        = start;
  assign bus.startAddress = startAddress;
  assign bus.done         = done;
  assign bus.haltPc       = haltPc;
  assign bus.cycles       = cycles;
  assign bus.timeout      = timeout;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: scoreboard bench for run_ctrl; expected completion records are
// queued when a run's ending stimulus is driven and checked on each done pulse.
module tb_run_ctrl;

  localparam int unsigned AW   = 16;
  localparam int unsigned CW   = 16;
  localparam int unsigned WDOG = 8;
`ifdef WATCHDOG_EN
  localparam bit WdogOn = 1'b1;
`else
  localparam bit WdogOn = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] haltPc;
    logic [CW-1:0] cycles;
    logic          timeout;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb[$];
  logic prevDone;

  run_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  run_ctrl #(
    .ADDR_WIDTH  (AW),
    .CNT_WIDTH   (CW),
    .START_CYCLES(2),
    .HALT_OPCODE (4'hF),
    .WDOG_LIMIT  (WDOG)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          checkVal("done_unexpected", 32'(bus.done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkVal("sb_haltPc",  32'(bus.haltPc),  32'(e.haltPc));
          checkVal("sb_cycles",  32'(bus.cycles),  32'(e.cycles));
          checkVal("sb_timeout", 32'(bus.timeout), 32'(e.timeout));
        end
        if (prevDone) checkVal("done_width", 32'(prevDone), 32'd0);
      end
      prevDone = bus.done;
    end else begin
      prevDone = 1'b0;
    end
  end

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_ack"},   32'(bus.ack),          32'd0);
    checkVal({tag, "_busy"},  32'(bus.busy),         32'd0);
    checkVal({tag, "_start"}, 32'(bus.start),        32'd0);
    checkVal({tag, "_saddr"}, 32'(bus.startAddress), 32'd0);
    checkVal({tag, "_done"},  32'(bus.done),         32'd0);
    checkVal({tag, "_hpc"},   32'(bus.haltPc),       32'd0);
    checkVal({tag, "_cyc"},   32'(bus.cycles),       32'd0);
    checkVal({tag, "_tmo"},   32'(bus.timeout),      32'd0);
  endtask

  // Launch one run from IDLE (called at a negedge) and drive it to its end.
  // haltAt/abortAt: RUN cycle index (1-based) of HALT / abort, 0 = never.
  task automatic runOnce(input logic [AW-1:0] a, input int haltAt, input logic [AW-1:0] hpc,
                         input int abortAt, input bit reqPulse, input bit keepReq);
    bit ended;
    bus.req    = 1'b1;
    bus.addr   = a;
    bus.abort  = 1'b0;
    bus.opcode = 4'h0;
    @(negedge clk);
    checkVal("ack_pulse",  32'(bus.ack),          32'd1);
    checkVal("load_start", 32'(bus.start),        32'd1);
    checkVal("load_busy",  32'(bus.busy),         32'd1);
    checkVal("start_addr", 32'(bus.startAddress), 32'(a));
    checkVal("clr_cycles", 32'(bus.cycles),       32'd0);
    checkVal("clr_haltpc", 32'(bus.haltPc),       32'd0);
    checkVal("clr_tmo",    32'(bus.timeout),      32'd0);
    if (!keepReq) bus.req = 1'b0;
    @(negedge clk);
    checkVal("ack_once",    32'(bus.ack),   32'd0);
    checkVal("load_start2", 32'(bus.start), 32'd1);
    ended = 1'b0;
    for (int k = 1; k <= 40 && !ended; k++) begin
      @(negedge clk);
      checkVal("run_cycles", 32'(bus.cycles), 32'(k));
      checkVal("run_start",  32'(bus.start),  32'd0);
      checkVal("run_busy",   32'(bus.busy),   32'd1);
      checkVal("run_noack",  32'(bus.ack),    32'd0);
      bus.opcode = (k == haltAt) ? 4'hF : 4'(k % 15);
      bus.pc     = (k == haltAt) ? hpc : AW'(16'h0100 + k);
      bus.abort  = (k == abortAt);
      if (reqPulse) bus.req = (k == 2);
      if (k == abortAt) begin
        ended = 1'b1;
      end else if (k == haltAt) begin
        sb.push_back('{haltPc: hpc, cycles: CW'(k), timeout: 1'b0});
        ended = 1'b1;
      end else if (WdogOn && k == int'(WDOG)) begin
        sb.push_back('{haltPc: AW'(16'h0100 + k), cycles: CW'(k), timeout: 1'b1});
        ended = 1'b1;
      end
    end
    if (!ended) checkVal("run_bound", 32'd0, 32'd1);
    @(negedge clk);
    checkVal("end_busy",  32'(bus.busy),  32'd0);
    checkVal("end_start", 32'(bus.start), 32'd0);
    checkVal("end_noack", 32'(bus.ack),   32'd0);
    if (abortAt != 0) begin
      checkVal("abort_done",   32'(bus.done),   32'd0);
      checkVal("abort_cycles", 32'(bus.cycles), 32'(abortAt));
      checkVal("abort_haltpc", 32'(bus.haltPc), 32'd0);
    end
    bus.abort  = 1'b0;
    bus.opcode = 4'h0;
    if (!keepReq) bus.req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    prevDone = 1'b0;
    bus.req    = 1'b0;
    bus.addr   = '0;
    bus.abort  = 1'b0;
    bus.pc     = '0;
    bus.opcode = 4'h0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: reset asserted mid-LOAD clears outputs immediately
    bus.req  = 1'b1;
    bus.addr = 16'h1234;
    @(negedge clk);
    checkVal("pre_rst_start", 32'(bus.start), 32'd1);
    bus.req = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkAllZero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkAllZero("post_rst");

    // 2: basic run, HALT at pc 9 on RUN cycle 5
    runOnce(16'h0005, 5, 16'h0009, 0, 1'b0, 1'b0);
    checkVal("hold_haltpc", 32'(bus.haltPc), 32'h9);
    @(negedge clk);
    checkVal("hold_cycles", 32'(bus.cycles), 32'd5);

    // 3: req held across DONE starts a back-to-back run at address 0
    runOnce(16'h00A0, 2, 16'h00A2, 0, 1'b0, 1'b1);
    @(negedge clk);
    checkVal("b2b_idle_ack",  32'(bus.ack),  32'd0);
    checkVal("b2b_idle_busy", 32'(bus.busy), 32'd0);
    runOnce(16'h0000, 3, 16'h0033, 0, 1'b0, 1'b0);
    @(negedge clk);

    // 4: abort together with HALT on RUN cycle 3
    runOnce(16'h0040, 3, 16'h0055, 3, 1'b0, 1'b0);
    @(negedge clk);
    checkVal("abort_hold_cyc", 32'(bus.cycles), 32'd3);

    // abort with req in IDLE: not accepted
    bus.req   = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    checkVal("abort_req_ack",  32'(bus.ack),  32'd0);
    checkVal("abort_req_busy", 32'(bus.busy), 32'd0);
    bus.req   = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);

    // 5: req pulsed during RUN is ignored
    runOnce(16'h0300, 4, 16'h0304, 0, 1'b1, 1'b0);
    @(negedge clk);
    checkVal("pulse_idle_ack", 32'(bus.ack), 32'd0);

    // 6: watchdog (or its absence)
    if (WdogOn) begin
      runOnce(16'h0500, 0, 16'h0000, 0, 1'b0, 1'b0);
      checkVal("wdog_timeout", 32'(bus.timeout), 32'd1);
      @(negedge clk);
      runOnce(16'h0600, int'(WDOG), 16'h0077, 0, 1'b0, 1'b0);
      checkVal("wdog_halt_wins", 32'(bus.timeout), 32'd0);
    end else begin
      runOnce(16'h0500, 0, 16'h0000, 12, 1'b0, 1'b0);
      checkVal("nowdog_timeout", 32'(bus.timeout), 32'd0);
    end
    @(negedge clk);

    checkVal("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
